// File: rtl/trading_engine.sv
// trading_engine: per-symbol threshold trade decisions, long-only position limit, FIFO'd valid/ready output
// Optional feature macro: TRADING_ENGINE_COOLDOWN_EN (per-symbol cooldown after each decision).
// Ports: clk, rst_n (async, active low); field_valid/msg_type/sym_id/order_id/price/volume parsed
// message in; dec_valid/dec_ready handshake with dec_type/dec_sym/dec_order_id/dec_price/dec_volume
// head fields out; drop_cnt counts decisions lost to a full queue (saturating).
module trading_engine #(
    parameter int NSYM        = 4,
    parameter int PRICE_W     = 32,
    parameter int VOL_W       = 32,
    parameter int BUY_THRESH  = 10000,
    parameter int SELL_THRESH = 20000,
    parameter int POS_LIMIT   = 1000,
    parameter int COOLDOWN    = 16,
    parameter int FIFO_DEPTH  = 4,
    localparam int SYM_W      = (NSYM > 1) ? $clog2(NSYM) : 1,
    localparam int POS_W      = $clog2(POS_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               field_valid,
    input  logic [7:0]         msg_type,
    input  logic [SYM_W-1:0]   sym_id,
    input  logic [63:0]        order_id,
    input  logic [PRICE_W-1:0] price,
    input  logic [VOL_W-1:0]   volume,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [7:0]         dec_type,
    output logic [SYM_W-1:0]   dec_sym,
    output logic [63:0]        dec_order_id,
    output logic [PRICE_W-1:0] dec_price,
    output logic [VOL_W-1:0]   dec_volume,
    output logic [15:0]        drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = VOL_W + 1;

    logic               sym_ok, cd_ok, cand, buy, sell, act, full, pop, push;
    logic [POS_W-1:0]   cur_pos, new_pos;
    logic [POS_W-1:0]   pos [NSYM];
    logic [SW-1:0]      pos_x, sum;
    logic [AW:0]        wr, rd;
    logic [AW-1:0]      ri;
    logic               m_buy   [FIFO_DEPTH];
    logic [SYM_W-1:0]   m_sym   [FIFO_DEPTH];
    logic [63:0]        m_oid   [FIFO_DEPTH];
    logic [PRICE_W-1:0] m_price [FIFO_DEPTH];
    logic [VOL_W-1:0]   m_vol   [FIFO_DEPTH];

    assign sym_ok  = {1'b0, sym_id} < (SYM_W + 1)'(NSYM);
    assign cur_pos = sym_ok ? pos[sym_id] : '0;
    // One extra bit keeps pos + volume from wrapping for any volume.
    assign pos_x   = SW'(cur_pos);
    assign sum     = pos_x + SW'(volume);
    assign buy     = price < PRICE_W'(BUY_THRESH) && sum <= SW'(POS_LIMIT);
    assign sell    = !buy && price > PRICE_W'(SELL_THRESH) && pos_x >= SW'(volume);
    assign new_pos = buy ? sum[POS_W-1:0] : cur_pos - POS_W'(volume);
    assign cand    = field_valid && msg_type == 8'h54 && sym_ok && volume != '0 && cd_ok;
    assign act     = cand && (buy || sell);

    assign ri        = rd[AW-1:0];
    assign dec_valid = wr != rd;
    assign full      = wr == {~rd[AW], rd[AW-1:0]};
    assign pop       = dec_valid && dec_ready;
    // A full queue still accepts when the head leaves on the same edge.
    assign push      = act && (!full || pop);

    assign dec_type     = dec_valid ? (m_buy[ri] ? 8'h42 : 8'h53) : 8'h00;
    assign dec_sym      = dec_valid ? m_sym[ri] : '0;
    assign dec_order_id = dec_valid ? m_oid[ri] : '0;
    assign dec_price    = dec_valid ? m_price[ri] : '0;
    assign dec_volume   = dec_valid ? m_vol[ri] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            m_buy[wr[AW-1:0]]   <= buy;
            m_sym[wr[AW-1:0]]   <= sym_id;
            m_oid[wr[AW-1:0]]   <= order_id;
            m_price[wr[AW-1:0]] <= price;
            m_vol[wr[AW-1:0]]   <= volume;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr       <= '0;
            rd       <= '0;
            drop_cnt <= '0;
            for (int s = 0; s < NSYM; s++) pos[s] <= '0;
        end else begin
            if (push) begin
                wr          <= wr + (AW + 1)'(1);
                pos[sym_id] <= new_pos;
            end
            if (pop) rd <= rd + (AW + 1)'(1);
            if (act && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef TRADING_ENGINE_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    logic [CD_W-1:0] cd [NSYM];

    assign cd_ok = sym_ok && cd[sym_id] == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSYM; s++) cd[s] <= '0;
        end else begin
            for (int s = 0; s < NSYM; s++)
                cd[s] <= (push && sym_id == SYM_W'(s)) ? CD_W'(COOLDOWN) :
                         (cd[s] != '0) ? cd[s] - CD_W'(1) : cd[s];
        end
    end
`else
    logic unused_cooldown;
    assign cd_ok           = 1'b1;
    assign unused_cooldown = COOLDOWN != 0;
`endif
endmodule

// File: tb/tb_trading_engine.sv
// tb_trading_engine: directed vector table plus multi-cycle sequences for trading_engine
module tb_trading_engine;
    logic        clk = 1'b0, rst_n = 1'b0, field_valid = 1'b0, dec_ready = 1'b0, dec_valid;
    logic [7:0]  msg_type = 8'h00, dec_type;
    logic [1:0]  sym_id = 2'd0, dec_sym;
    logic [63:0] order_id = 64'd0, dec_order_id;
    logic [31:0] price = 32'd0, volume = 32'd0, dec_price, dec_volume;
    logic [15:0] drop_cnt;
    int checks = 0, errors = 0;

    trading_engine dut (
        .clk(clk), .rst_n(rst_n), .field_valid(field_valid), .msg_type(msg_type),
        .sym_id(sym_id), .order_id(order_id), .price(price), .volume(volume),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_type(dec_type), .dec_sym(dec_sym),
        .dec_order_id(dec_order_id), .dec_price(dec_price), .dec_volume(dec_volume),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [7:0]  mt;
        logic [1:0]  sym;
        logic [31:0] price;
        logic [31:0] vol;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] p, input logic [31:0] v);
        field_valid = 1'b1;
        msg_type    = 8'h54;
        sym_id      = s;
        price       = p;
        volume      = v;
        order_id    = {32'hC0DE_0000, 14'd0, s, p[15:0]};
    endtask

    task automatic idle();
        field_valid = 1'b0;
    endtask

    task automatic head(input string n, input logic [7:0] t, input logic [1:0] s,
                        input logic [31:0] p, input logic [31:0] v);
        chk({n, "_valid"}, dec_valid, 1'b1);
        chk({n, "_type"}, dec_type, t);
        chk({n, "_sym"}, dec_sym, s);
        chk({n, "_price"}, dec_price, p);
        chk({n, "_vol"}, dec_volume, v);
    endtask

    initial begin
        tbl[0]  = '{1, 8'h54, 1, 9000,  100,  8'h42};
        tbl[1]  = '{1, 8'h54, 2, 5000,  600,  8'h42};
        tbl[2]  = '{1, 8'h54, 2, 5000,  500,  8'h00};
        tbl[3]  = '{1, 8'h54, 2, 5000,  400,  8'h42};
        tbl[4]  = '{1, 8'h54, 2, 5000,  1,    8'h00};
        tbl[5]  = '{1, 8'h54, 0, 9999,  300,  8'h42};
        tbl[6]  = '{1, 8'h54, 0, 25000, 400,  8'h00};
        tbl[7]  = '{1, 8'h54, 0, 10000, 100,  8'h00};
        tbl[8]  = '{1, 8'h54, 0, 20000, 100,  8'h00};
        tbl[9]  = '{1, 8'h54, 0, 25000, 300,  8'h53};
        tbl[10] = '{1, 8'h54, 0, 25000, 1,    8'h00};
        tbl[11] = '{1, 8'h41, 1, 9000,  100,  8'h00};
        tbl[12] = '{1, 8'h54, 1, 9000,  0,    8'h00};
        tbl[13] = '{1, 8'h54, 1, 20001, 100,  8'h53};
        tbl[14] = '{1, 8'h54, 1, 20001, 1,    8'h00};
        tbl[15] = '{1, 8'h54, 3, 1,     1000, 8'h42};
        tbl[16] = '{0, 8'h54, 3, 25000, 1000, 8'h00};
        tbl[17] = '{1, 8'h54, 3, 25000, 1000, 8'h53};
        tbl[18] = '{1, 8'h54, 0, 5000,  32'hFFFF_FFFF, 8'h00};

        #12;
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_type", dec_type, 8'h00);
        chk("rst_sym", dec_sym, 2'd0);
        chk("rst_oid", dec_order_id, 64'd0);
        chk("rst_price", dec_price, 32'd0);
        chk("rst_vol", dec_volume, 32'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        step();
        rst_n = 1'b1;
        dec_ready = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            field_valid = tbl[i].fv;
            msg_type    = tbl[i].mt;
            sym_id      = tbl[i].sym;
            price       = tbl[i].price;
            volume      = tbl[i].vol;
            order_id    = 64'hA5A5_0000_0000_0000 | 64'(i);
            step();
            idle();
            if (tbl[i].exp == 8'h00) begin
                chk($sformatf("v%0d_valid", i), dec_valid, 1'b0);
            end else begin
                head($sformatf("v%0d", i), tbl[i].exp, tbl[i].sym, tbl[i].price, tbl[i].vol);
                chk($sformatf("v%0d_oid", i), dec_order_id, 64'hA5A5_0000_0000_0000 | 64'(i));
            end
            repeat (18) step();
        end

`ifdef TRADING_ENGINE_COOLDOWN_EN
        drive(3, 100, 10);
        step();
        head("cd_first", 8'h42, 3, 100, 10);
        drive(1, 100, 5);
        step();
        head("cd_other_sym", 8'h42, 1, 100, 5);
        idle();
        repeat (14) step();
        drive(3, 100, 10);
        step();
        chk("cd_blocked_n16", dec_valid, 1'b0);
        step();
        head("cd_open_n17", 8'h42, 3, 100, 10);
        idle();
        step();
`else
        drive(2, 25000, 600);
        step();
        head("b2b_first", 8'h53, 2, 25000, 600);
        step();
        chk("b2b_second_rejected", dec_valid, 1'b0);
        idle();
        step();
`endif

        repeat (18) step();
        dec_ready = 1'b0;
        drive(0, 100, 50);
        step();
        head("st_e1", 8'h42, 0, 100, 50);
        drive(1, 200, 60);
        step();
        drive(2, 25000, 100);
        step();
        drive(3, 300, 70);
        step();
        idle();
        head("st_hold_a", 8'h42, 0, 100, 50);
        repeat (17) step();
        head("st_hold_b", 8'h42, 0, 100, 50);
        chk("st_drop0", drop_cnt, 16'd0);
        drive(0, 400, 950);
        step();
        idle();
        chk("st_drop1", drop_cnt, 16'd1);
        head("st_hold_c", 8'h42, 0, 100, 50);
        dec_ready = 1'b1;
        head("dr0", 8'h42, 0, 100, 50);
        step();
        head("dr1", 8'h42, 1, 200, 60);
        step();
        head("dr2", 8'h53, 2, 25000, 100);
        step();
        head("dr3", 8'h42, 3, 300, 70);
        step();
        chk("dr_empty", dec_valid, 1'b0);
        drive(0, 400, 951);
        step();
        chk("drop_pos_limit", dec_valid, 1'b0);
        drive(0, 400, 950);
        step();
        head("drop_pos_kept", 8'h42, 0, 400, 950);
        idle();
        step();

        dec_ready = 1'b0;
        repeat (18) step();
        drive(1, 9000, 1);
        step();
        drive(2, 25000, 1);
        step();
        drive(3, 9000, 1);
        step();
        drive(0, 25000, 1);
        step();
        idle();
        repeat (18) step();
        drive(2, 25000, 2);
        dec_ready = 1'b1;
        step();
        idle();
        chk("fp_drop_same", drop_cnt, 16'd1);
        head("fp_h0", 8'h53, 2, 25000, 1);
        step();
        head("fp_h1", 8'h42, 3, 9000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dec_valid, 1'b0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", dec_valid, 1'b0);
        drive(2, 5000, 1000);
        step();
        head("post_rst_pos2", 8'h42, 2, 5000, 1000);
        drive(0, 25000, 1);
        step();
        idle();
        chk("post_rst_pos0", dec_valid, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
